// File: rtl/tlul_host_arb_ctrl.sv
// tlul_host_arb_ctrl: round-robin TL-UL host request arbiter with grant lock and outstanding limits.
// Optional per-requester grant counters are enabled by defining TLUL_ARB_PERF_EN.
module tlul_host_arb_ctrl #(
   parameter int N              = 4,
   parameter int DW             = 32,
   parameter int MaxOutstanding = 2,
   parameter int IdxW           = $clog2(N),
   parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N-1:0]      req_i,
   input  logic [N*DW-1:0]   data_i,
   output logic [N-1:0]      gnt_o,
   output logic              valid_o,
   output logic [DW-1:0]     data_o,
   output logic [IdxW-1:0]   idx_o,
   input  logic              ready_i,
   input  logic              rsp_done_i,
   input  logic [IdxW-1:0]   rsp_idx_i,
   output logic              busy_o,
   output logic              err_o,
   output logic [N*16-1:0]   perf_gnt_cnt_o
);
   typedef enum logic {IDLE, LOCKED} state_e;
   state_e                  state_q;
   logic [IdxW-1:0]         ptr_q, lock_q, win, sel, nxt;
   logic [N-1:0][CntW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]            elig;
   logic                    any_elig, hs, err_q, err_d, idx_hit, idx_zero, dec;
   int                      j;
   always_comb begin
      for (int i = 0; i < N; i++) elig[i] = req_i[i] & (cnt_q[i] != CntW'(MaxOutstanding));
      win = ptr_q;
      any_elig = 1'b0;
      j = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         j = j >= N ? j - N : j;
         if (!any_elig && elig[j]) begin
            any_elig = 1'b1;
            win = IdxW'(j);
         end
      end
   end
   // A locked grant is held regardless of what the requesters do afterwards.
   assign sel     = state_q == LOCKED ? lock_q : win;
   assign valid_o = state_q == LOCKED || any_elig;
   assign hs      = valid_o & ready_i;
   assign nxt     = sel == IdxW'(N - 1) ? '0 : sel + 1'b1;
   assign idx_o   = valid_o ? sel : '0;
   assign data_o  = valid_o ? data_i[int'(sel)*DW +: DW] : '0;
   assign err_o   = err_q;
   always_comb begin
      idx_hit = 1'b0;
      idx_zero = 1'b0;
      busy_o = 1'b0;
      dec = 1'b0;
      for (int i = 0; i < N; i++) begin
         gnt_o[i] = hs && sel == IdxW'(i);
         dec = rsp_done_i && rsp_idx_i == IdxW'(i) && cnt_q[i] != '0;
         cnt_d[i] = cnt_q[i] + CntW'(gnt_o[i]) - CntW'(dec);
         busy_o = busy_o | (cnt_q[i] != '0);
         if (rsp_idx_i == IdxW'(i)) begin
            idx_hit = 1'b1;
            idx_zero = cnt_q[i] == '0;
         end
      end
      err_d = err_q | (rsp_done_i & (~idx_hit | idx_zero));
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
         if (hs) begin
            ptr_q   <= nxt;
            state_q <= IDLE;
         end else if (valid_o && state_q == IDLE) begin
            lock_q  <= win;
            state_q <= LOCKED;
         end
      end
   end
`ifdef TLUL_ARB_PERF_EN
   logic [N-1:0][15:0] perf_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) perf_q <= '0;
      else for (int i = 0; i < N; i++) if (gnt_o[i] && perf_q[i] != 16'hFFFF) perf_q[i] <= perf_q[i] + 16'd1;
   end
   assign perf_gnt_cnt_o = perf_q;
`else
   assign perf_gnt_cnt_o = '0;
`endif
endmodule
